// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - CRC-8 width, default polynomial and single-bit step functions
package crc_pkg;

    localparam int          CRC_W             = 8;
    localparam logic [7:0]  CRC8_POLY_DEFAULT = 8'h07;

    // Augmented division: shift the new bit in, subtract P when x^8 falls out.
    function automatic logic [CRC_W-1:0] crc8_div_step(
        input logic [CRC_W-1:0] r,
        input logic             din,
        input logic [CRC_W-1:0] poly
    );
        logic [CRC_W:0] t;
        t = {r, din};
        return t[CRC_W] ? (t[CRC_W-1:0] ^ poly) : t[CRC_W-1:0];
    endfunction

    // Direct LFSR: the input bit is folded into the feedback, so no augmentation is needed.
    function automatic logic [CRC_W-1:0] crc8_lfsr_step(
        input logic [CRC_W-1:0] r,
        input logic             din,
        input logic [CRC_W-1:0] poly
    );
        logic fb;
        fb = din ^ r[CRC_W-1];
        return {r[CRC_W-2:0], 1'b0} ^ (fb ? poly : '0);
    endfunction

endpackage

// File: rtl/crc8_serial_if.sv
// rtl/crc8_serial_if.sv - serial bit input and the two CRC register outputs
interface crc8_serial_if;
    import crc_pkg::*;

    logic             in;
    logic [CRC_W-1:0] crc1;
    logic [CRC_W-1:0] crc2;

    modport master (output in, input crc1, input crc2);
    modport slave  (input in, output crc1, output crc2);

endinterface

// File: rtl/crc8_serial.sv
// rtl/crc8_serial.sv - bit-serial CRC-8 with division-style and LFSR registers in parallel
module crc8_serial
    import crc_pkg::*;
#(
    parameter logic [CRC_W-1:0] POLY = CRC8_POLY_DEFAULT,
    parameter logic [CRC_W-1:0] INIT = 8'h00
) (
    input  logic          CLK,
    input  logic          RST,
    crc8_serial_if.slave  bus
);

    logic [CRC_W-1:0] crc1_q, crc1_d;
    logic [CRC_W-1:0] crc2_q, crc2_d;

    always_comb begin
        crc1_d = crc8_div_step(crc1_q, bus.in, POLY);
        crc2_d = crc8_lfsr_step(crc2_q, bus.in, POLY);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            crc1_q <= INIT;
            crc2_q <= INIT;
        end else begin
            crc1_q <= crc1_d;
            crc2_q <= crc2_d;
        end
    end

    assign bus.crc1 = crc1_q;
    assign bus.crc2 = crc2_q;

endmodule

// File: tb/tb_crc8_serial.sv
// tb/tb_crc8_serial.sv - directed and random self-checking bench for crc8_serial
module tb_crc8_serial;
    import crc_pkg::*;

    logic CLK;
    logic RST;
    int   n_tests;
    int   n_fail;

    crc8_serial_if bus ();

    crc8_serial #(.POLY(8'h07), .INIT(8'h00)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic feed_bit(input logic b);
        bus.in = b;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset(input int edges);
        RST = 1'b1;
        for (int i = 0; i < edges; i++) begin
            bus.in = i[0];
            @(posedge CLK);
            #1;
        end
        RST = 1'b0;
    endtask

    task automatic feed_word(input logic [31:0] w);
        for (int i = 31; i >= 0; i--) feed_bit(w[i]);
    endtask

    task automatic feed_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) feed_bit(b[i]);
    endtask

    // Reference: polynomial long division of {w, 8'h00} by x^8 + POLY.
    function automatic logic [7:0] ref_crc(input logic [31:0] w);
        logic [39:0] v;
        v = {w, 8'h00};
        for (int i = 39; i >= 8; i--)
            if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
        return v[7:0];
    endfunction

    logic [31:0] frame_word;
    logic [31:0] w;
    logic [7:0]  c2_mid;
    logic [7:0]  exp_crc;

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        RST        = 1'b1;
        bus.in     = 1'b0;
        frame_word = 32'h0000_000D;

        do_reset(2);
        check_eq("reset_crc1", bus.crc1, 8'h00);
        check_eq("reset_crc2", bus.crc2, 8'h00);

        feed_bit(1'b1);
        check_eq("bit1_crc1", bus.crc1, 8'h01);
        check_eq("bit1_crc2", bus.crc2, 8'h07);
        feed_byte(8'h00);
        check_eq("bit1_aug_crc1", bus.crc1, 8'h07);

        do_reset(1);
        feed_word(frame_word);
        check_eq("frame32_crc2", bus.crc2, 8'h23);
        feed_byte(8'h00);
        check_eq("frame40_crc1", bus.crc1, 8'h23);
        check_eq("frame40_crc2", bus.crc2, 8'hE9);

        do_reset(1);
        feed_word(frame_word);
        feed_byte(8'h23);
        check_eq("check_crc2", bus.crc2, 8'h00);
        feed_byte(8'h00);
        check_eq("check_aug_crc1", bus.crc1, 8'h00);

        do_reset(1);
        for (int i = 31; i >= 12; i--) feed_bit(frame_word[i]);
        do_reset(1);
        check_eq("midrst_crc1", bus.crc1, 8'h00);
        check_eq("midrst_crc2", bus.crc2, 8'h00);
        feed_word(frame_word);
        check_eq("midrst32_crc2", bus.crc2, 8'h23);
        feed_byte(8'h00);
        check_eq("midrst40_crc1", bus.crc1, 8'h23);
        check_eq("midrst40_crc2", bus.crc2, 8'hE9);

        for (int k = 0; k < 1000; k++) begin
            w = $urandom;
            exp_crc = ref_crc(w);
            do_reset(1);
            feed_word(w);
            c2_mid = bus.crc2;
            check_eq("rand_crc2_ref", c2_mid, exp_crc);
            feed_byte(8'h00);
            check_eq("rand_crc1_ref", bus.crc1, exp_crc);
            check_eq("rand_crc1_eq_crc2", bus.crc1, c2_mid);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
